// File: rtl/vec4_op_sequencer.sv
// Four-register, 16-bit op sequencer: loads operands, runs a short stored program of
// register ops one per cycle, then publishes r3..r0 with a one-cycle done pulse.
module vec4_op_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic [15:0]   a1,
    input  logic [15:0]   a0,
    input  logic [15:0]   b1,
    input  logic [15:0]   b0,
    output logic          busy,
    output logic          done,
    output logic [15:0]   y3,
    output logic [15:0]   y2,
    output logic [15:0]   y1,
    output logic [15:0]   y0
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);

    state_e      state_q;
    logic [7:0]  mem_q [DEPTH];
    logic [15:0] r_q   [4];
    logic [15:0] y_q   [4];
    logic [AW:0] pc_q;
    logic [AW:0] len_q;
    logic        busy_q;
    logic        done_q;

    logic [AW-1:0] pc_idx;
    logic [2:0]    op;
    logic [1:0]    dst;
    logic [1:0]    src;
    logic [15:0]   rd_val;
    logic [15:0]   rs_val;
    logic [15:0]   prod;
    logic [15:0]   alu_res;
    logic [AW:0]   len_clamped;

    // Bit 4 of the instruction word is reserved and never decoded.
    assign pc_idx      = pc_q[AW-1:0];
    assign op          = mem_q[pc_idx][7:5];
    assign dst         = mem_q[pc_idx][3:2];
    assign src         = mem_q[pc_idx][1:0];
    assign rd_val      = r_q[dst];
    assign rs_val      = r_q[src];
    assign prod        = rd_val * rs_val;
    assign len_clamped = (prog_len > DepthLen) ? DepthLen : prog_len;

    always_comb begin
        alu_res = rd_val;
        unique case (op)
            3'd0: alu_res = rd_val;
            3'd1: alu_res = rs_val;
            3'd2: alu_res = {15'd0, (rs_val == 16'd0)};
            3'd3: alu_res = rd_val & rs_val;
            3'd4: alu_res = rd_val | rs_val;
            3'd5: alu_res = rd_val ^ rs_val;
            3'd6: alu_res = rd_val + rs_val;
            3'd7: alu_res = prod;
            default: alu_res = rd_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= '0;
            len_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (prog_we) begin
                        mem_q[prog_addr] <= prog_data;
                    end
                    if (start) begin
                        r_q[0]  <= a0;
                        r_q[1]  <= a1;
                        r_q[2]  <= b0;
                        r_q[3]  <= b1;
                        pc_q    <= '0;
                        len_q   <= len_clamped;
                        busy_q  <= 1'b1;
                        state_q <= (len_clamped == '0) ? StDone : StExec;
                    end
                end
                StExec: begin
                    r_q[dst] <= alu_res;
                    pc_q     <= pc_q + 1'b1;
                    if (pc_q == len_q - 1'b1) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        y_q[i] <= r_q[i];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y3   = y_q[3];
    assign y2   = y_q[2];
    assign y1   = y_q[1];
    assign y0   = y_q[0];

endmodule

// File: tb/tb_vec4_op_sequencer.sv
// Scoreboard bench for vec4_op_sequencer: stimulus pushes expected results and done
// cycles, an independent monitor pops and compares on every done pulse.
module tb_vec4_op_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [7:0]    prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic [15:0]   a1 = '0, a0 = '0, b1 = '0, b0 = '0;
    logic          busy, done;
    logic [15:0]   y3, y2, y1, y0;

    vec4_op_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0), .busy(busy), .done(done),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0][15:0] y;   // [3]=y3 .. [0]=y0
        int               at;
        string            name;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_cycle"}, cyc, e.at);
                chk({e.name, "_y3"}, {16'd0, y3}, {16'd0, e.y[3]});
                chk({e.name, "_y2"}, {16'd0, y2}, {16'd0, e.y[2]});
                chk({e.name, "_y1"}, {16'd0, y1}, {16'd0, e.y[1]});
                chk({e.name, "_y0"}, {16'd0, y0}, {16'd0, e.y[0]});
            end
        end
    end

    task automatic write_prog(input logic [AW-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Drives start for one edge; returns at the negedge following E0.
    task automatic issue(input logic [AW:0] len, input logic [15:0] ia0, input logic [15:0] ia1,
                         input logic [15:0] ib0, input logic [15:0] ib1,
                         input logic [3:0][15:0] ey, input int eff_len, input string name,
                         input logic we = 1'b0, input logic [AW-1:0] wa = '0,
                         input logic [7:0] wd = 8'h00);
        exp_t e;
        @(negedge clk);
        start = 1'b1; prog_len = len; a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
        prog_we = we; prog_addr = wa; prog_data = wd;
        e.y = ey; e.at = cyc + 1 + eff_len + 1; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
            sb.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_y3", {16'd0, y3}, 32'd0);
        chk("rst_y2", {16'd0, y2}, 32'd0);
        chk("rst_y1", {16'd0, y1}, 32'd0);
        chk("rst_y0", {16'd0, y0}, 32'd0);

        // NOT r3,r3 ; OR r3,r2 ; AND r1,r2 ; XOR r3,r3
        write_prog(4'd0, 8'h4F);
        write_prog(4'd1, 8'h8E);
        write_prog(4'd2, 8'h66);
        write_prog(4'd3, 8'hAF);

        issue(5'd4, 16'h1234, 16'hFFFF, 16'h00F0, 16'h0000,
              {16'h0000, 16'h00F0, 16'h00F0, 16'h1234}, 4, "sc1");
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sc1_busy_e0p%0d", k), {31'd0, busy}, {31'd0, (k < 5)});
            if (k < 5) @(negedge clk);
        end
        wait_drain("sc1");

        // Start and program write mid-run must both be ignored.
        issue(5'd4, 16'h1234, 16'hFFFF, 16'h00F0, 16'h0000,
              {16'h0000, 16'h00F0, 16'h00F0, 16'h1234}, 4, "sc4");
        @(negedge clk);
        start = 1'b1; a0 = 16'hAAAA; a1 = 16'hBBBB; b0 = 16'hCCCC; b1 = 16'hDDDD;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_drain("sc4");

        // mem[0] still NOT r3,r3 (0xFF would be MUL r3,r3 giving 0).
        issue(5'd1, 16'h0005, 16'h0006, 16'h0007, 16'h0000,
              {16'h0001, 16'h0007, 16'h0006, 16'h0005}, 1, "rerun");
        wait_drain("rerun");

        issue(5'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
              {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, "sc2");
        wait_drain("sc2");

        // MUL r0,r2 ; ADD r1,r3 -- second word written on the start edge.
        write_prog(4'd0, 8'hE2);
        issue(5'd2, 16'h0100, 16'hFFFF, 16'h0300, 16'h0002,
              {16'h0002, 16'h0300, 16'h0001, 16'h0000}, 2, "sc3", 1'b1, 4'd1, 8'hC7);
        wait_drain("sc3");

        // Abort mid-run with reset; no done may follow.
        issue(5'd4, 16'h1234, 16'hFFFF, 16'h00F0, 16'h0000,
              {16'h0000, 16'h00F0, 16'h00F0, 16'h1234}, 4, "sc5");
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("sc5_busy", {31'd0, busy}, 32'd0);
        chk("sc5_done", {31'd0, done}, 32'd0);
        chk("sc5_y3", {16'd0, y3}, 32'd0);
        chk("sc5_y2", {16'd0, y2}, 32'd0);
        chk("sc5_y1", {16'd0, y1}, 32'd0);
        chk("sc5_y0", {16'd0, y0}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Memory is all NOP now; prog_len 20 clamps to 16.
        issue(5'd20, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
              {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 16, "sc6");
        wait_drain("sc6");

        issue(5'd4, 16'h0BAD, 16'hCAFE, 16'hBEEF, 16'hF00D,
              {16'hF00D, 16'hBEEF, 16'hCAFE, 16'h0BAD}, 4, "nop_pass");
        wait_drain("nop_pass");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
